ghost_check_arbiter: RTL and testbench

//  Round-robin arbiter sharing one collision-check unit among N_GHOSTS ghost movers.

---
 rtl/ghost_check_arbiter.sv | 160 ++++++++++++++++
 tb/tb_ghost_check_arbiter.sv | 237 +++++++++++++++++++++++
 2 files changed

// File: rtl/ghost_check_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : ghost_check_arbiter
//  Brief    : Round-robin arbiter sharing one collision checker among ghosts.
//  Revision : 1.0 - initial release
// ============================================================================
module ghost_check_arbiter #(
    parameter int N_GHOSTS = 4,
    parameter int ID_W     = 2,
    parameter int CHK_LAT  = 2
) (
    input  logic                  clkdiv,
    input  logic                  rst,
    input  logic                  pause,
    input  logic [N_GHOSTS-1:0]   req,
    input  logic [N_GHOSTS*10-1:0] req_x,
    input  logic [N_GHOSTS*9-1:0] req_y,
    input  logic [N_GHOSTS*2-1:0] req_dir,
    output logic [9:0]            chk_x,
    output logic [8:0]            chk_y,
    output logic [1:0]            chk_dir,
    output logic                  chk_start,
    input  logic                  chk_result,
    output logic [N_GHOSTS-1:0]   ack,
    output logic                  ack_free,
    output logic [ID_W-1:0]       grant_id,
    output logic                  busy
);

    localparam int CNT_W = (CHK_LAT > 1) ? $clog2(CHK_LAT) : 1;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ISSUE = 2'd1,
        S_WAIT  = 2'd2,
        S_RESP  = 2'd3
    } state_t;

    state_t                state_q, state_d;
    logic [CNT_W-1:0]      cnt_q, cnt_d;
    logic [ID_W-1:0]       ptr_q, ptr_d;
    logic [ID_W-1:0]       grant_id_q, grant_id_d;
    logic [9:0]            chk_x_q, chk_x_d;
    logic [8:0]            chk_y_q, chk_y_d;
    logic [1:0]            chk_dir_q, chk_dir_d;
    logic                  chk_start_q, chk_start_d;
    logic [N_GHOSTS-1:0]   ack_q, ack_d;
    logic                  ack_free_q, ack_free_d;
    logic                  busy_q, busy_d;

    logic                  win_found;
    int                    win_idx;
    int                    scan_idx;

    // Search starts just after the last served ghost, so it becomes lowest priority.
    always_comb begin
        win_found = 1'b0;
        win_idx   = 0;
        scan_idx  = 0;
        for (int k = 1; k <= N_GHOSTS; k++) begin
            scan_idx = int'(ptr_q) + k;
            if (scan_idx >= N_GHOSTS) begin
                scan_idx = scan_idx - N_GHOSTS;
            end
            if (!win_found && req[scan_idx]) begin
                win_found = 1'b1;
                win_idx   = scan_idx;
            end
        end
    end

    always_comb begin
        state_d     = state_q;
        cnt_d       = cnt_q;
        ptr_d       = ptr_q;
        grant_id_d  = grant_id_q;
        chk_x_d     = chk_x_q;
        chk_y_d     = chk_y_q;
        chk_dir_d   = chk_dir_q;
        chk_start_d = 1'b0;
        ack_d       = '0;
        ack_free_d  = ack_free_q;
        busy_d      = busy_q;

        case (state_q)
            S_IDLE: begin
                if (!pause && win_found) begin
                    grant_id_d  = ID_W'(win_idx);
                    ptr_d       = ID_W'(win_idx);
                    chk_x_d     = req_x[win_idx*10 +: 10];
                    chk_y_d     = req_y[win_idx*9 +: 9];
                    chk_dir_d   = req_dir[win_idx*2 +: 2];
                    chk_start_d = 1'b1;
                    busy_d      = 1'b1;
                    state_d     = S_ISSUE;
                end
            end
            S_ISSUE: begin
                cnt_d   = CNT_W'(CHK_LAT - 1);
                state_d = S_WAIT;
            end
            S_WAIT: begin
                if (cnt_q == '0) begin
                    ack_free_d = chk_result;
                    ack_d      = N_GHOSTS'(1) << grant_id_q;
                    state_d    = S_RESP;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                end
            end
            S_RESP: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
            default: begin
                busy_d  = 1'b0;
                state_d = S_IDLE;
            end
        endcase
    end

    always_ff @(posedge clkdiv) begin
        if (!rst) begin
            state_q     <= S_IDLE;
            cnt_q       <= '0;
            ptr_q       <= ID_W'(N_GHOSTS - 1);
            grant_id_q  <= '0;
            chk_x_q     <= '0;
            chk_y_q     <= '0;
            chk_dir_q   <= '0;
            chk_start_q <= 1'b0;
            ack_q       <= '0;
            ack_free_q  <= 1'b0;
            busy_q      <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            ptr_q       <= ptr_d;
            grant_id_q  <= grant_id_d;
            chk_x_q     <= chk_x_d;
            chk_y_q     <= chk_y_d;
            chk_dir_q   <= chk_dir_d;
            chk_start_q <= chk_start_d;
            ack_q       <= ack_d;
            ack_free_q  <= ack_free_d;
            busy_q      <= busy_d;
        end
    end

    assign chk_x     = chk_x_q;
    assign chk_y     = chk_y_q;
    assign chk_dir   = chk_dir_q;
    assign chk_start = chk_start_q;
    assign ack       = ack_q;
    assign ack_free  = ack_free_q;
    assign grant_id  = grant_id_q;
    assign busy      = busy_q;

endmodule
`default_nettype wire

// File: tb/tb_ghost_check_arbiter.sv
`default_nettype none
// ============================================================================
//  Module   : tb_ghost_check_arbiter
//  Brief    : Directed self-checking bench for ghost_check_arbiter.
//  Revision : 1.0 - initial release
// ============================================================================
module tb_ghost_check_arbiter;

    logic        clkdiv = 1'b0;
    logic        rst;
    logic        pause;
    logic [3:0]  req;
    logic [39:0] req_x;
    logic [35:0] req_y;
    logic [7:0]  req_dir;
    logic [9:0]  chk_x;
    logic [8:0]  chk_y;
    logic [1:0]  chk_dir;
    logic        chk_start;
    logic        chk_result;
    logic [3:0]  ack;
    logic        ack_free;
    logic [1:0]  grant_id;
    logic        busy;

    int n_checks = 0;
    int n_fail   = 0;
    int cyc      = 0;

    always #5 clkdiv = ~clkdiv;

    ghost_check_arbiter #(
        .N_GHOSTS (4),
        .ID_W     (2),
        .CHK_LAT  (2)
    ) dut (
        .clkdiv     (clkdiv),
        .rst        (rst),
        .pause      (pause),
        .req        (req),
        .req_x      (req_x),
        .req_y      (req_y),
        .req_dir    (req_dir),
        .chk_x      (chk_x),
        .chk_y      (chk_y),
        .chk_dir    (chk_dir),
        .chk_start  (chk_start),
        .chk_result (chk_result),
        .ack        (ack),
        .ack_free   (ack_free),
        .grant_id   (grant_id),
        .busy       (busy)
    );

    task automatic tick();
        @(posedge clkdiv);
        #1;
        cyc++;
    endtask

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: observed %0d expected %0d", tag, got, exp);
        end
    endtask

    task automatic set_pos(input int g, input int x, input int y, input int d);
        req_x[g*10 +: 10] = 10'(x);
        req_y[g*9 +: 9]   = 9'(y);
        req_dir[g*2 +: 2] = 2'(d);
    endtask

    task automatic wait_ack(output int at);
        at = -1;
        for (int k = 0; k < 20; k++) begin
            tick();
            if (|ack) begin
                at = cyc;
                break;
            end
        end
        check("ack_seen", 32'(|ack), 1);
    endtask

    task automatic wait_start();
        for (int k = 0; k < 20; k++) begin
            tick();
            if (chk_start) break;
        end
        check("start_seen", 32'(chk_start), 1);
    endtask

    initial begin
        int at;
        int last;
        int starts;
        int exp_g;

        rst        = 1'b0;
        pause      = 1'b0;
        req        = 4'b0000;
        req_x      = '0;
        req_y      = '0;
        req_dir    = '0;
        chk_result = 1'b1;

        // Test 1: single request, exact latency
        set_pos(0, 320, 240, 3);
        req = 4'b0001;
        tick();
        tick();
        check("rst_busy", 32'(busy), 0);
        check("rst_ack", 32'(ack), 0);
        check("rst_start", 32'(chk_start), 0);
        check("rst_gid", 32'(grant_id), 0);
        check("rst_chk_x", 32'(chk_x), 0);
        check("rst_ack_free", 32'(ack_free), 0);
        rst = 1'b1;
        tick();
        check("t1_start_c2", 32'(chk_start), 1);
        check("t1_busy", 32'(busy), 1);
        check("t1_gid", 32'(grant_id), 0);
        check("t1_chk_x", 32'(chk_x), 320);
        check("t1_chk_y", 32'(chk_y), 240);
        check("t1_chk_dir", 32'(chk_dir), 3);
        tick();
        check("t1_start_pulse", 32'(chk_start), 0);
        check("t1_no_ack_c3", 32'(ack), 0);
        tick();
        check("t1_no_ack_c4", 32'(ack), 0);
        tick();
        check("t1_ack_c5", 32'(ack), 1);
        check("t1_ack_free", 32'(ack_free), 1);
        req = 4'b0000;
        tick();
        check("t1_ack_pulse", 32'(ack), 0);
        check("t1_idle", 32'(busy), 0);

        // Test 2: all four held, round-robin 0,1,2,3 from reset
        rst = 1'b0;
        tick();
        for (int g = 0; g < 4; g++) set_pos(g, 100 + g, 50 + g, g);
        req  = 4'b1111;
        rst  = 1'b1;
        last = 0;
        for (int g = 0; g < 4; g++) begin
            wait_ack(at);
            check("t2_ack", 32'(ack), 32'(1 << g));
            check("t2_gid", 32'(grant_id), 32'(g));
            check("t2_chk_x", 32'(chk_x), 32'(100 + g));
            check("t2_chk_y", 32'(chk_y), 32'(50 + g));
            check("t2_chk_dir", 32'(chk_dir), 32'(g));
            if (g > 0) check("t2_period", 32'(at - last), 5);
            last   = at;
            req[g] = 1'b0;
        end

        // Test 3: ghosts 0 and 2 re-raise after each ack; must alternate
        set_pos(0, 10, 1, 0);
        set_pos(2, 30, 3, 2);
        req = 4'b0101;
        for (int k = 0; k < 4; k++) begin
            exp_g = (k % 2 == 0) ? 0 : 2;
            wait_ack(at);
            check("t3_gid", 32'(grant_id), 32'(exp_g));
            check("t3_ack", 32'(ack), 32'(1 << exp_g));
            req[exp_g] = 1'b0;
            if (k < 2) begin
                tick();
                req[exp_g] = 1'b1;
            end
        end

        // Test 4: blocked result, position change after grant is ignored
        set_pos(1, 320, 7, 1);
        chk_result = 1'b0;
        req = 4'b0010;
        wait_start();
        check("t4_gid", 32'(grant_id), 1);
        set_pos(1, 100, 7, 1);
        wait_ack(at);
        check("t4_ack", 32'(ack), 32'b0010);
        check("t4_ack_free", 32'(ack_free), 0);
        check("t4_chk_x", 32'(chk_x), 320);
        req = 4'b0000;
        chk_result = 1'b1;

        // Test 5: pause during WAIT finishes current, blocks next
        req = 4'b0110;
        wait_start();
        check("t5_gid", 32'(grant_id), 2);
        tick();
        pause = 1'b1;
        wait_ack(at);
        check("t5_ack", 32'(ack), 32'b0100);
        check("t5_ack_free", 32'(ack_free), 1);
        req[2] = 1'b0;
        starts = 0;
        for (int k = 0; k < 8; k++) begin
            tick();
            starts += int'(chk_start);
        end
        check("t5_no_start", 32'(starts), 0);
        check("t5_idle", 32'(busy), 0);
        pause = 1'b0;
        wait_ack(at);
        check("t5_ack_after", 32'(ack), 32'b0010);
        req = 4'b0000;

        // Test 6: reset mid-WAIT aborts, ghost 0 first afterwards
        req = 4'b0100;
        wait_start();
        tick();
        rst = 1'b0;
        tick();
        check("t6_busy", 32'(busy), 0);
        check("t6_ack", 32'(ack), 0);
        check("t6_gid", 32'(grant_id), 0);
        set_pos(0, 55, 5, 1);
        req = 4'b1111;
        rst = 1'b1;
        wait_ack(at);
        check("t6_first_ack", 32'(ack), 32'b0001);
        check("t6_first_gid", 32'(grant_id), 0);
        check("t6_chk_x", 32'(chk_x), 55);
        req = 4'b0000;
        tick();
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
